// File: rtl/io_buf_pkg.sv
// ============================================================================
// Module      : io_buf_pkg
// Description : Shared types, defaults and LED decode for the I/O buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_buf_pkg;

    localparam int DATA_W_DFLT = 2;
    localparam int LED_W_DFLT  = 2 ** DATA_W_DFLT;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READ   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [LED_W_DFLT-1:0] onehot(input logic [DATA_W_DFLT-1:0] v);
        logic [LED_W_DFLT-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick with a last-served pointer register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] win
);

    // 1 means requester 1 was served last, so requester 0 wins the next tie.
    logic r_last;

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (upd) begin
            r_last <= win[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_buf_arb.sv
// ============================================================================
// Module      : io_buf_arb
// Description : Grants one of two requesters, writes its word to the buffer,
//               reads it back after a settle cycle and shows it on the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_buf_arb
    import io_buf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int HOLD_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [DATA_W-1:0]    data0,
    input  logic [DATA_W-1:0]    data1,
    output logic [1:0]           gnt,
    output logic                 done,
    output logic                 busy,
    output logic                 buf_wr_en,
    output logic                 buf_rd_en,
    output logic [DATA_W-1:0]    buf_wdata,
    input  logic [DATA_W-1:0]    buf_rdata,
    output logic [DATA_W-1:0]    rd_q,
    output logic [2**DATA_W-1:0] led
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       win;
    logic             grant_upd;

    assign grant_upd = (state == ST_IDLE) && (|req);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .upd   (grant_upd),
        .win   (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            gnt       <= 2'b00;
            done      <= 1'b0;
            busy      <= 1'b0;
            buf_wr_en <= 1'b0;
            buf_rd_en <= 1'b0;
            buf_wdata <= '0;
            rd_q      <= '0;
            led       <= onehot('0);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt       <= win;
                        buf_wdata <= win[1] ? data1 : data0;
                        buf_wr_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    buf_wr_en <= 1'b0;
                    state     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    buf_rd_en <= 1'b1;
                    hold_cnt  <= CNT_W'(HOLD_CYC);
                    state     <= ST_READ;
                end
                ST_READ: begin
                    // Capture on the edge that closes the final read cycle.
                    if (hold_cnt == CNT_W'(1)) begin
                        buf_rd_en <= 1'b0;
                        rd_q      <= buf_rdata;
                        led       <= onehot(buf_rdata);
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_buf_arb.sv
// ============================================================================
// Module      : tb_io_buf_arb
// Description : Bench for io_buf_arb with HOLD_CYC=4 and HOLD_CYC=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_buf_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] data0 = 2'b00;
    logic [1:0] data1 = 2'b00;

    logic [1:0] gnt   [2];
    logic       done  [2];
    logic       busy  [2];
    logic       wr    [2];
    logic       rd    [2];
    logic [1:0] wdata [2];
    logic [1:0] rdq   [2];
    logic [3:0] led   [2];
    logic [1:0] mem   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction timeline counted in edges since grant.
    int         hold   [2] = '{4, 1};
    bit         act    [2];
    int         g_edge [2];
    int         m_win  [2];
    bit         m_last [2];
    logic [1:0] m_wd   [2];
    logic [1:0] m_q    [2];
    int         edge_n = 0;

    always #5 clk = ~clk;

    io_buf_arb #(.DATA_W(2), .HOLD_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt[0]), .done(done[0]), .busy(busy[0]), .buf_wr_en(wr[0]),
        .buf_rd_en(rd[0]), .buf_wdata(wdata[0]), .buf_rdata(mem[0]),
        .rd_q(rdq[0]), .led(led[0])
    );

    io_buf_arb #(.DATA_W(2), .HOLD_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt[1]), .done(done[1]), .busy(busy[1]), .buf_wr_en(wr[1]),
        .buf_rd_en(rd[1]), .buf_wdata(wdata[1]), .buf_rdata(mem[1]),
        .rd_q(rdq[1]), .led(led[1])
    );

    // Echoing buffer per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr[i]) mem[i] <= wdata[i];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]    = 1'b0;
            m_last[i] = 1'b1;
            m_wd[i]   = 2'd0;
            m_q[i]    = 2'd0;
        end
    endtask

    task automatic model_edge();
        int k;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            k = edge_n - g_edge[i];
            if (act[i] && k == hold[i] + 2) m_q[i] = m_wd[i];
            if (act[i] && k == hold[i] + 3) begin
                act[i] = 1'b0;
            end else if (!act[i] && req != 2'b00) begin
                if (req == 2'b01)      m_win[i] = 0;
                else if (req == 2'b10) m_win[i] = 1;
                else                   m_win[i] = m_last[i] ? 0 : 1;
                m_last[i] = (m_win[i] == 1);
                m_wd[i]   = (m_win[i] == 1) ? data1 : data0;
                g_edge[i] = edge_n;
                act[i]    = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        int k;
        for (int i = 0; i < 2; i++) begin
            k = edge_n - g_edge[i];
            check($sformatf("gnt[h%0d]", hold[i]), int'(gnt[i]), act[i] ? (1 << m_win[i]) : 0);
            check($sformatf("busy[h%0d]", hold[i]), int'(busy[i]), int'(act[i]));
            check($sformatf("wr_en[h%0d]", hold[i]), int'(wr[i]), int'(act[i] && k == 0));
            check($sformatf("rd_en[h%0d]", hold[i]), int'(rd[i]),
                  int'(act[i] && k >= 2 && k <= hold[i] + 1));
            check($sformatf("done[h%0d]", hold[i]), int'(done[i]), int'(act[i] && k == hold[i] + 2));
            check($sformatf("wdata[h%0d]", hold[i]), int'(wdata[i]), int'(m_wd[i]));
            check($sformatf("rd_q[h%0d]", hold[i]), int'(rdq[i]), int'(m_q[i]));
            check($sformatf("led[h%0d]", hold[i]), int'(led[i]), 1 << m_q[i]);
            check($sformatf("overlap[h%0d]", hold[i]), int'(wr[i] & rd[i]), 0);
        end
    endtask

    task automatic cycle(input logic [1:0] r, input logic [1:0] d0, input logic [1:0] d1);
        @(negedge clk);
        req   = r;
        data0 = d0;
        data1 = d1;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    // Asserted mid-cycle so the asynchronous path is what clears the outputs.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request; data0 changes right after grant and must be ignored.
        cycle(2'b01, 2'b11, 2'b00);
        repeat (8) cycle(2'b00, 2'b00, 2'b00);

        // Tie straight after reset: requester 0 first, then requester 1.
        do_reset();
        repeat (20) cycle(2'b11, 2'b01, 2'b10);
        repeat (2) cycle(2'b00, 2'b00, 2'b00);

        // Request dropped during the transaction.
        repeat (4) cycle(2'b01, 2'b10, 2'b01);
        repeat (6) cycle(2'b00, 2'b10, 2'b01);

        // Reset while the HOLD_CYC=4 instance is mid-READ.
        cycle(2'b10, 2'b01, 2'b11);
        repeat (3) cycle(2'b00, 2'b01, 2'b11);
        do_reset();
        repeat (3) cycle(2'b00, 2'b00, 2'b00);

        // Every word value from both ports.
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < 2; p++) begin
                cycle(p ? 2'b10 : 2'b01, 2'(w), 2'(3 - w));
                repeat (8) cycle(2'b00, 2'(3 - w), 2'(w));
            end
        end

        // Randomised traffic.
        repeat (500) begin
            cycle(2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/io_buf_arb.md
# io_buf_arb

Two-port arbiter and sequencer for the 2-bit I/O word buffer on the Genesys2 I/O designs. It grants one of two requesters, writes that requester's word into the buffer with a one-cycle write strobe, and waits one settle cycle. It then holds the buffer read enable, captures the read-back word and drives it onto the board LEDs as a one-hot pattern. It sits between the switch/button front-ends and the buffer, and is the only agent allowed to drive the buffer's write and read enables.

## Interface
- `DATA_W`, 2, width of buffer word and requester data.
- `HOLD_CYC`, 4, number of cycles read enable is held; legal range ≥1.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in 2: per-requester transfer request, level.
- `data0` in DATA_W: requester 0 write word.
- `data1` in DATA_W: requester 1 write word.
- `gnt` out 2: one-hot grant, held for the whole transaction.
- `done` out 1: single-cycle completion pulse.
- `busy` out 1: high in any state other than IDLE.
- `buf_wr_en` out 1: buffer write strobe.
- `buf_rd_en` out 1: buffer read enable.
- `buf_wdata` out DATA_W: word to the buffer.
- `buf_rdata` in DATA_W: word from the buffer.
- `rd_q` out DATA_W: last read-back word.
- `led` out 2^DATA_W: one-hot decode of `rd_q`; `led[rd_q]` is 1.

## Operation
- **States:** IDLE → WRITE → SETTLE → READ → DONE → IDLE.
- **IDLE:**
  - With any `req` bit set: pick the winner, latch the winner's data into `buf_wdata`, set `gnt`, go to WRITE.
  - With no request: stay in IDLE.
- **Arbitration:** round-robin with a last-served pointer.
  - A single request always wins.
  - If both requesters ask, the one not served last wins.
  - The pointer updates at grant.
- **WRITE:** `buf_wr_en` = 1 for exactly one cycle.
- **SETTLE:** one cycle with both enables at 0.
- **READ:**
  - `buf_rd_en` = 1 for HOLD_CYC cycles, counted by a down-counter of width clog2(HOLD_CYC+1).
  - On the edge ending the last READ cycle, capture `buf_rdata` into `rd_q` and update `led`.
- **DONE:** `done` = 1 and `gnt` is still held; the next state is IDLE, where `gnt` clears.
- **Requester contract:**
  - `data0`/`data1` are sampled only at grant.
  - A `req` that drops mid-transaction is ignored; the transaction completes.
  - A `req` still high in IDLE re-arbitrates. The other requester, if it is requesting, wins the tie.
- **Enable overlap:** `buf_wr_en` and `buf_rd_en` are never high in the same cycle.

## Timing
- Cycle numbering: E0 is the IDLE edge that samples `req`.
  - WRITE occupies E0→E1.
  - SETTLE occupies E1→E2.
  - READ occupies E2→E2+HOLD_CYC.
  - DONE occupies E2+HOLD_CYC→E3+HOLD_CYC.
- Total transaction length: HOLD_CYC+3 cycles. The next grant is possible at edge E3+HOLD_CYC.
- **Reset values:**
  - `gnt`, `done`, `busy`, `buf_wr_en`, `buf_rd_en` = 0.
  - `buf_wdata`, `rd_q` = 0, and `led` = 0001.
  - State = IDLE and the pointer = "1 served last", so requester 0 wins the first tie.
- **Reset mid-transaction:** all outputs take their reset values immediately. No `done` pulse is issued, and the interrupted transfer is not resumed.
- **Registered outputs:** every output is registered. `led` changes on the same edge as `rd_q`.

## Structure
- **Package `io_buf_pkg`:** state enum, `DATA_W` default, and a one-hot decode function used for `led`.
- **Sub-module `rr_arb2`:** two-way round-robin pick plus the last-served pointer register. Its inputs are `req` and a grant-update strobe; its output is the one-hot winner.
- **Top level:** FSM, HOLD counter, data/readback registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-READ → all enables, `gnt` and `busy` drop to 0 within the same cycle; `led`=0001 and `rd_q`=0.
- **Single request:** `req`=01, `data0`=2'b11, buffer model echoes its input → `gnt`=01 for 7 cycles; `buf_wr_en` pulses once at cycle 1; `buf_rd_en` is high for cycles 3–6; `done` at cycle 7; `rd_q`=3; `led`=1000.
- **Tie after reset:** `req`=11 with `data0`=2'b01 and `data1`=2'b10 → requester 0 is granted first and `rd_q`=1, `led`=0010. Requester 1 is granted next and `rd_q`=2, `led`=0100.
- **Data change after grant:** change `data0` to 2'b00 one cycle after grant → `buf_wdata` stays 2'b11 and `rd_q`=3.
- **Request drop mid-transaction:** deassert `req[0]` during READ → the transaction completes, `done` pulses, and the FSM returns to IDLE with `gnt`=00.
- **Enable overlap and width sweep:** check that `buf_wr_en & buf_rd_en` is never 1 across all four word values 0–3 from both ports. Rerun with HOLD_CYC=1 → `buf_rd_en` is a single cycle and the transaction is 4 cycles.
